// File: rtl/sha512_arbiter.sv
// sha512_arbiter: round-robin sequencer sharing one sha512 core among NumReq
// requesters. It grants the core, streams the owner's words into the core FIFO,
// captures the digest and scrubs the core (sha_en low) between jobs.
// Optional stall watchdog in Stream: define SHA512_ARB_WDOG_EN.
// fifo_rdata_o layout: data in [71:8], byte mask in [7:0].
module sha512_arbiter #(
  parameter int NumReq     = 2,
  parameter int WdogCycles = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumReq-1:0]        req_i,
  input  logic [NumReq-1:0][127:0] msg_len_i,
  input  logic [NumReq-1:0]        in_valid_i,
  input  logic [NumReq-1:0][63:0]  in_data_i,
  input  logic [NumReq-1:0][7:0]   in_mask_i,
  input  logic [NumReq-1:0]        in_last_i,
  output logic [NumReq-1:0]        in_ready_o,
  output logic [NumReq-1:0]        grant_o,
  output logic [NumReq-1:0]        done_o,
  output logic [NumReq-1:0]        abort_o,
  output logic [511:0]             digest_o,
  output logic                     sha_en_o,
  output logic                     hash_start_o,
  output logic                     hash_process_o,
  input  logic                     hash_done_i,
  output logic [127:0]             message_length_o,
  output logic                     fifo_rvalid_o,
  output logic [71:0]              fifo_rdata_o,
  input  logic                     fifo_rready_i,
  input  logic [7:0][63:0]         digest_i
);

  localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic [2:0] {
    Idle, Start, Stream, Process, WaitDone, Done, Clear
  } state_e;

  state_e          state_reg, state_next;
  logic [IdxW-1:0] owner_reg, owner_next;
  logic [IdxW-1:0] ptr_reg, ptr_next;
  logic [127:0]    len_reg, len_next;
  logic [511:0]    digest_reg, digest_next;

  logic            pick_found;
  logic [IdxW-1:0] pick_idx;
  logic            owner_req, owner_valid, owner_last;
  logic            job_active, grant_active, stream_live;
  logic            beat_accept, job_drop, wdog_fire;

  // Requester index base+off, wrapping modulo NumReq.
  function automatic logic [IdxW-1:0] wrap_add(input logic [IdxW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NumReq) sum = sum - NumReq;
    return IdxW'(sum);
  endfunction

  assign owner_req    = req_i[owner_reg];
  assign owner_valid  = in_valid_i[owner_reg];
  assign owner_last   = in_last_i[owner_reg];
  assign job_active   = (state_reg == Start) || (state_reg == Stream) ||
                        (state_reg == Process) || (state_reg == WaitDone);
  assign grant_active = job_active || (state_reg == Done);
  // A dropped request kills the stream handshake in the same cycle.
  assign stream_live  = (state_reg == Stream) && owner_req;
  assign beat_accept  = stream_live && owner_valid && fifo_rready_i;

`ifdef SHA512_ARB_WDOG_EN
  logic [31:0] wdog_reg, wdog_next;

  // Stall counter: counts Stream cycles without an accepted beat.
  always_comb begin
    wdog_next = wdog_reg + 32'd1;
    if (state_reg != Stream || beat_accept) wdog_next = '0;
  end

  // Stall counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) wdog_reg <= '0;
    else         wdog_reg <= wdog_next;
  end

  assign wdog_fire = (state_reg == Stream) && !beat_accept &&
                     (wdog_reg == 32'(WdogCycles - 1));
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = ^WdogCycles;
  assign wdog_fire = 1'b0;
`endif

  // Round-robin pick: lowest requesting index at or above ptr.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (!pick_found && req_i[wrap_add(ptr_reg, i)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_add(ptr_reg, i);
      end
    end
  end

  // Next-state logic; an abort overrides the normal transition.
  always_comb begin
    state_next  = state_reg;
    owner_next  = owner_reg;
    ptr_next    = ptr_reg;
    len_next    = len_reg;
    digest_next = digest_reg;
    job_drop    = 1'b0;
    case (state_reg)
      Idle: begin
        if (pick_found) begin
          owner_next = pick_idx;
          len_next   = msg_len_i[pick_idx];
          state_next = Start;
        end
      end
      Start:    state_next = (len_reg == '0) ? Process : Stream;
      Stream:   if (beat_accept && owner_last) state_next = Process;
      Process:  state_next = WaitDone;
      WaitDone: begin
        if (hash_done_i) begin
          digest_next = digest_i;
          state_next  = Done;
        end
      end
      Done: begin
        ptr_next   = wrap_add(owner_reg, 1);
        state_next = Clear;
      end
      Clear:    state_next = Idle;
      default:  state_next = Idle;
    endcase
    if (job_active && (!owner_req || wdog_fire)) begin
      job_drop    = 1'b1;
      ptr_next    = wrap_add(owner_reg, 1);
      digest_next = digest_reg;
      state_next  = Clear;
    end
  end

  // State, owner, pointer, latched length and captured digest.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= Idle;
      owner_reg  <= '0;
      ptr_reg    <= '0;
      len_reg    <= '0;
      digest_reg <= '0;
    end else begin
      state_reg  <= state_next;
      owner_reg  <= owner_next;
      ptr_reg    <= ptr_next;
      len_reg    <= len_next;
      digest_reg <= digest_next;
    end
  end

  // Per-requester decode of grant, handshake and status pulses.
  for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
    logic is_owner;
    assign is_owner       = (owner_reg == IdxW'(gi));
    assign grant_o[gi]    = grant_active && is_owner;
    assign in_ready_o[gi] = stream_live && is_owner && fifo_rready_i;
    assign done_o[gi]     = (state_reg == Done) && is_owner;
    assign abort_o[gi]    = job_drop && is_owner;
  end

  assign sha_en_o         = (state_reg != Idle) && (state_reg != Clear);
  assign hash_start_o     = (state_reg == Start);
  assign hash_process_o   = (state_reg == Process);
  assign fifo_rvalid_o    = stream_live && owner_valid;
  assign fifo_rdata_o     = stream_live ? {in_data_i[owner_reg], in_mask_i[owner_reg]} : '0;
  assign message_length_o = len_reg;
  assign digest_o         = digest_reg;

endmodule

// File: tb/tb_sha512_arbiter.sv
// tb_sha512_arbiter: scenario tasks drive requesters and a behavioural core;
// a negedge monitor pops expected beats and digests from scoreboard queues.
module tb_sha512_arbiter;
  localparam int NumReq     = 2;
  localparam int WdogCycles = 16;

  logic                     clk_i = 1'b0;
  logic                     rst_ni = 1'b0;
  logic [NumReq-1:0]        req_i;
  logic [NumReq-1:0][127:0] msg_len_i;
  logic [NumReq-1:0]        in_valid_i;
  logic [NumReq-1:0][63:0]  in_data_i;
  logic [NumReq-1:0][7:0]   in_mask_i;
  logic [NumReq-1:0]        in_last_i;
  logic [NumReq-1:0]        in_ready_o;
  logic [NumReq-1:0]        grant_o;
  logic [NumReq-1:0]        done_o;
  logic [NumReq-1:0]        abort_o;
  logic [511:0]             digest_o;
  logic                     sha_en_o, hash_start_o, hash_process_o;
  logic                     hash_done_i;
  logic [127:0]             message_length_o;
  logic                     fifo_rvalid_o;
  logic [71:0]              fifo_rdata_o;
  logic                     fifo_rready_i;
  logic [7:0][63:0]         digest_i;

  sha512_arbiter #(.NumReq(NumReq), .WdogCycles(WdogCycles)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .msg_len_i(msg_len_i),
    .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_mask_i(in_mask_i),
    .in_last_i(in_last_i), .in_ready_o(in_ready_o), .grant_o(grant_o),
    .done_o(done_o), .abort_o(abort_o), .digest_o(digest_o), .sha_en_o(sha_en_o),
    .hash_start_o(hash_start_o), .hash_process_o(hash_process_o),
    .hash_done_i(hash_done_i), .message_length_o(message_length_o),
    .fifo_rvalid_o(fifo_rvalid_o), .fifo_rdata_o(fifo_rdata_o),
    .fifo_rready_i(fifo_rready_i), .digest_i(digest_i)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [71:0]       beat_q[$];
  logic [511:0]      dig_q[$];
  logic [NumReq-1:0] own_q[$];
  logic [71:0]       mon_beat;
  logic [511:0]      mon_dig;
  logic [NumReq-1:0] mon_own;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Scoreboard monitor: core-side beats and done pulses, sampled on negedge.
  always @(negedge clk_i) begin
    if (rst_ni === 1'b1 && fifo_rvalid_o === 1'b1 && fifo_rready_i === 1'b1) begin
      n_cmp++;
      if (beat_q.size() == 0) begin
        n_bad++;
        $display("FAIL beat: got unexpected beat %h, required none", fifo_rdata_o);
      end else begin
        mon_beat = beat_q.pop_front();
        $display("beat    data=%h mask=%h", fifo_rdata_o[71:8], fifo_rdata_o[7:0]);
        if (fifo_rdata_o !== mon_beat) begin
          n_bad++;
          $display("FAIL beat: got %h required %h", fifo_rdata_o, mon_beat);
        end
      end
    end
    if (rst_ni === 1'b1 && done_o !== '0) begin
      n_cmp++;
      if (dig_q.size() == 0) begin
        n_bad++;
        $display("FAIL done: got unexpected done_o %b, required none", done_o);
      end else begin
        mon_dig = dig_q.pop_front();
        mon_own = own_q.pop_front();
        $display("done    owner=%b word0=%h", done_o, digest_o[63:0]);
        if (digest_o !== mon_dig || done_o !== mon_own) begin
          n_bad++;
          $display("FAIL done: got owner %b digest %h required owner %b digest %h",
                   done_o, digest_o, mon_own, mon_dig);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    req_i = '0; msg_len_i = '0; in_valid_i = '0; in_data_i = '0;
    in_mask_i = '0; in_last_i = '0; hash_done_i = 1'b0; digest_i = '0;
  endtask

  // One single-beat job for requester r, with a behavioural core answering.
  task automatic run_job(input int r, input logic [127:0] len, input logic [63:0] word,
                         input logic [7:0] mask, input logic [63:0] dig0,
                         output int t_req, output int t_start, output int t_proc,
                         output int t_hd, output int t_done,
                         output bit any_ready, output bit tmo);
    int n;
    logic [511:0] d;
    tmo = 1'b0;
    any_ready = 1'b0;
    req_i[r] = 1'b1; msg_len_i[r] = len; in_data_i[r] = word;
    in_mask_i[r] = mask; in_last_i[r] = 1'b1; in_valid_i[r] = 1'b1;
    if (len != 0) beat_q.push_back({word, mask});
    t_req = cyc;
    n = 0;
    while (!(hash_start_o && grant_o[r]) && n < 200) begin tick(); n++; end
    if (n >= 200) tmo = 1'b1;
    t_start = cyc;
    n = 0;
    while (!hash_process_o && n < 200) begin
      any_ready |= in_ready_o[r];
      tick(); n++;
    end
    if (n >= 200) tmo = 1'b1;
    t_proc = cyc;
    in_valid_i[r] = 1'b0; in_last_i[r] = 1'b0;
    tick(); tick();
    for (int k = 0; k < 8; k++) d[k*64 +: 64] = dig0 ^ {8{8'(k)}};
    digest_i = d;
    hash_done_i = 1'b1;
    dig_q.push_back(d);
    own_q.push_back(NumReq'(1) << r);
    t_hd = cyc;
    n = 0;
    do begin tick(); hash_done_i = 1'b0; n++; end while (!done_o[r] && n < 50);
    if (n >= 50) tmo = 1'b1;
    t_done = cyc;
    req_i[r] = 1'b0;
    $display("job     req=%0d len=%0d start=%0d done=%0d", r, len, t_start, t_done);
  endtask

  task automatic test_reset();
    idle_inputs();
    fifo_rready_i = 1'b1;
    rst_ni = 1'b0;
    tick(); tick(); tick();
    n_cmp++;
    if ({grant_o, done_o, abort_o, in_ready_o, sha_en_o, hash_start_o,
         hash_process_o, fifo_rvalid_o} !== '0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got grant %b done %b abort %b ready %b en %b start %b proc %b rvalid %b, required all 0",
               grant_o, done_o, abort_o, in_ready_o, sha_en_o, hash_start_o, hash_process_o, fifo_rvalid_o);
    end
    n_cmp++;
    if (digest_o !== '0 || message_length_o !== '0 || fifo_rdata_o !== '0) begin
      n_bad++;
      $display("FAIL reset_data: got digest %h len %h rdata %h, required 0",
               digest_o, message_length_o, fifo_rdata_o);
    end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_abc();
    int tr, ts, tp, th, td;
    bit rdy, tmo;
    run_job(0, 128'd24, 64'h6162630000000000, 8'hE0, 64'hddaf35a193617aba,
            tr, ts, tp, th, td, rdy, tmo);
    n_cmp++;
    if (tmo) begin n_bad++; $display("FAIL abc_timeout: got timeout, required completion"); end
    n_cmp++;
    if (ts - tr !== 1) begin n_bad++; $display("FAIL abc_start_lat: got %0d required 1", ts - tr); end
    n_cmp++;
    if (tp - ts !== 2) begin n_bad++; $display("FAIL abc_proc_lat: got %0d required 2", tp - ts); end
    n_cmp++;
    if (td - th !== 1 || digest_o[63:0] !== 64'hddaf35a193617aba) begin
      n_bad++;
      $display("FAIL abc_done: got lat %0d word0 %h required 1 ddaf35a193617aba", td - th, digest_o[63:0]);
    end
    tick();
    n_cmp++;
    if (sha_en_o !== 1'b0 || grant_o !== '0) begin
      n_bad++;
      $display("FAIL abc_clear: got en %b grant %b required 0 00", sha_en_o, grant_o);
    end
    tick();
  endtask

  task automatic test_both();
    int tr0, ts0, tp0, th0, td0, tr1, ts1, tp1, th1, td1;
    bit rdy, tmo0, tmo1;
    rst_ni = 1'b0; tick(); rst_ni = 1'b1;
    req_i[1] = 1'b1; msg_len_i[1] = 128'd16;
    run_job(0, 128'd24, 64'h0123456789abcdef, 8'hFF, 64'h0a0b0c0d0e0f1011,
            tr0, ts0, tp0, th0, td0, rdy, tmo0);
    run_job(1, 128'd16, 64'hfedcba9876543210, 8'hC0, 64'h1122334455667788,
            tr1, ts1, tp1, th1, td1, rdy, tmo1);
    n_cmp++;
    if (tmo0 || ts0 - tr0 !== 1) begin
      n_bad++;
      $display("FAIL both_first: got timeout %b lat %0d, required requester 0 at latency 1", tmo0, ts0 - tr0);
    end
    n_cmp++;
    if (tmo1) begin n_bad++; $display("FAIL both_second: got timeout, required completion"); end
    n_cmp++;
    if (ts1 - td0 !== 3) begin n_bad++; $display("FAIL both_turnaround: got %0d required 3", ts1 - td0); end
    tick(); tick();
  endtask

  task automatic test_len0();
    int tr, ts, tp, th, td;
    bit rdy, tmo;
    run_job(1, 128'd0, 64'hdeadbeefdeadbeef, 8'hFF, 64'hcf83e1357eefb8bd,
            tr, ts, tp, th, td, rdy, tmo);
    n_cmp++;
    if (tmo) begin n_bad++; $display("FAIL len0_timeout: got timeout, required completion"); end
    n_cmp++;
    if (rdy !== 1'b0) begin n_bad++; $display("FAIL len0_ready: got in_ready 1 required 0"); end
    n_cmp++;
    if (tp - ts !== 1) begin n_bad++; $display("FAIL len0_proc_lat: got %0d required 1", tp - ts); end
    n_cmp++;
    if (digest_o[63:0] !== 64'hcf83e1357eefb8bd) begin
      n_bad++;
      $display("FAIL len0_digest: got %h required cf83e1357eefb8bd", digest_o[63:0]);
    end
    tick(); tick();
  endtask

  task automatic test_abort();
    logic [511:0] prev;
    int tr, ts, tp, th, td;
    bit rdy, tmo;
    prev = digest_o;
    req_i = 2'b11; msg_len_i[0] = 128'd128; in_valid_i[0] = 1'b0; msg_len_i[1] = 128'd24;
    tick();
    n_cmp++;
    if (grant_o !== 2'b01) begin n_bad++; $display("FAIL abort_grant: got %b required 01", grant_o); end
    tick(); tick();
    req_i[0] = 1'b0;
    @(negedge clk_i);
    n_cmp++;
    if (abort_o !== 2'b01 || in_ready_o !== 2'b00) begin
      n_bad++;
      $display("FAIL abort_pulse: got abort %b ready %b required 01 00", abort_o, in_ready_o);
    end
    tick();
    n_cmp++;
    if (sha_en_o !== 1'b0 || grant_o !== '0 || abort_o !== '0 || digest_o !== prev) begin
      n_bad++;
      $display("FAIL abort_clear: got en %b grant %b abort %b word0 %h required 0 00 00 %h",
               sha_en_o, grant_o, abort_o, digest_o[63:0], prev[63:0]);
    end
    run_job(1, 128'd24, 64'h6162630000000000, 8'hE0, 64'h5555aaaa5555aaaa,
            tr, ts, tp, th, td, rdy, tmo);
    n_cmp++;
    if (tmo || ts - tr !== 2) begin
      n_bad++;
      $display("FAIL abort_next: got timeout %b lat %0d required 0 2", tmo, ts - tr);
    end
    tick(); tick();
  endtask

  task automatic test_wdog();
    int n;
    int first;
    req_i[0] = 1'b1; msg_len_i[0] = 128'd128; in_data_i[0] = 64'h1234;
    in_mask_i[0] = 8'hFF; in_last_i[0] = 1'b0; in_valid_i[0] = 1'b1;
    beat_q.push_back({64'h1234, 8'hFF});
    n = 0;
    while (!hash_start_o && n < 50) begin tick(); n++; end
    tick();
    tick();
    in_valid_i[0] = 1'b0;
    first = 0;
`ifdef SHA512_ARB_WDOG_EN
    for (int k = 1; k <= WdogCycles + 4; k++) begin
      @(negedge clk_i);
      if (abort_o[0] === 1'b1) begin first = k; break; end
      tick();
    end
    n_cmp++;
    if (first !== WdogCycles) begin
      n_bad++;
      $display("FAIL wdog_abort_cycle: got %0d required %0d", first, WdogCycles);
    end
    tick();
`else
    for (int k = 1; k <= 10000; k++) begin
      @(negedge clk_i);
      if (abort_o !== '0 && first == 0) first = k;
      tick();
    end
    n_cmp++;
    if (first !== 0 || grant_o !== 2'b01) begin
      n_bad++;
      $display("FAIL wdog_none: got abort at %0d grant %b required none 01", first, grant_o);
    end
    req_i[0] = 1'b0;
    @(negedge clk_i);
    tick();
`endif
    req_i[0] = 1'b0;
    n_cmp++;
    if (sha_en_o !== 1'b0 || grant_o !== '0) begin
      n_bad++;
      $display("FAIL wdog_clear: got en %b grant %b required 0 00", sha_en_o, grant_o);
    end
    tick();
  endtask

  task automatic test_async_reset();
    int n;
    int tr, ts, tp, th, td;
    bit rdy, tmo;
    req_i[0] = 1'b1; msg_len_i[0] = 128'd24; in_data_i[0] = 64'h6162630000000000;
    in_mask_i[0] = 8'hE0; in_last_i[0] = 1'b1; in_valid_i[0] = 1'b1;
    beat_q.push_back({64'h6162630000000000, 8'hE0});
    n = 0;
    while (!hash_process_o && n < 50) begin tick(); n++; end
    in_valid_i[0] = 1'b0;
    tick();
    n_cmp++;
    if (sha_en_o !== 1'b1 || grant_o !== 2'b01) begin
      n_bad++;
      $display("FAIL arst_pre: got en %b grant %b required 1 01", sha_en_o, grant_o);
    end
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({grant_o, done_o, abort_o, in_ready_o, sha_en_o, hash_start_o,
         hash_process_o, fifo_rvalid_o} !== '0 || digest_o !== '0 || message_length_o !== '0) begin
      n_bad++;
      $display("FAIL arst_outputs: got grant %b en %b word0 %h len %h required all 0",
               grant_o, sha_en_o, digest_o[63:0], message_length_o);
    end
    idle_inputs();
    tick();
    rst_ni = 1'b1;
    tick();
    run_job(0, 128'd24, 64'h6162630000000000, 8'hE0, 64'hddaf35a193617aba,
            tr, ts, tp, th, td, rdy, tmo);
    n_cmp++;
    if (tmo || digest_o[63:0] !== 64'hddaf35a193617aba) begin
      n_bad++;
      $display("FAIL arst_rerun: got timeout %b word0 %h required 0 ddaf35a193617aba", tmo, digest_o[63:0]);
    end
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_abc();
    test_both();
    test_len0();
    test_abort();
    test_wdog();
    test_async_reset();
    n_cmp++;
    if (beat_q.size() != 0 || dig_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d beats %0d digests pending required 0 0",
               beat_q.size(), dig_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL sim_timeout: got no finish by 3000000 required finish");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/sha512_arbiter.md
# sha512_arbiter

Sequencer and round-robin arbiter that shares one `sha512` core among `NumReq` requesters. It grants the core to one requester at a time and drives `sha_en`, `hash_start` and `hash_process`. It routes the granted requester's word stream into the core's FIFO port, captures the digest on `hash_done`, and scrubs the core between jobs. It sits between the host-side message sources and the `sha512` instance.

## Interface
Parameters:
- `NumReq`, 2: number of requesters, 2..8.
- `WdogCycles`, 1024: stall limit in cycles; used only with `SHA512_ARB_WDOG_EN`.

Ports (clock and reset first):
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_i`  in  NumReq  job request, level; held until `done_o` or `abort_o`.
- `msg_len_i`  in  NumReq×128  message length in bits, byte-based; sampled at grant.
- `in_valid_i`  in  NumReq  word valid.
- `in_data_i`  in  NumReq×64  message word.
- `in_mask_i`  in  NumReq×8  byte mask.
- `in_last_i`  in  NumReq  final word of the message.
- `in_ready_o`  out  NumReq  word accepted when valid and ready are both high.
- `grant_o`  out  NumReq  one-hot current owner.
- `done_o`  out  NumReq  one-cycle pulse; `digest_o` is valid in that cycle.
- `abort_o`  out  NumReq  one-cycle pulse; the job was dropped.
- `digest_o`  out  512  captured digest, word 0 in the LSBs.
- `sha_en_o`, `hash_start_o`, `hash_process_o`  out  1  core controls.
- `hash_done_i`  in  1  from the core.
- `message_length_o`  out  128  to the core.
- `fifo_rvalid_o`  out  1, `fifo_rdata_o`  out  `sha_fifo_t` {data 64, mask 8}, `fifo_rready_i`  in  1: core FIFO port.
- `digest_i`  in  8×64  core digest.

## Operation
- States: `Idle`, `Start`, `Stream`, `Process`, `WaitDone`, `Done`, `Clear`.
- `Idle`:
  - If any `req_i` is set, select owner `g` round-robin, searching upward from `ptr`.
  - Latch `g` and `msg_len_i[g]`, then go to `Start`.
- `Start`:
  - `hash_start_o`=1 for this single cycle.
  - Go to `Stream`, or to `Process` if the latched length is 0.
- `Stream`:
  - Pass-through wiring: `fifo_rvalid_o`=`in_valid_i[g]`, `fifo_rdata_o`={`in_data_i[g]`,`in_mask_i[g]`}, `in_ready_o[g]`=`fifo_rready_i`.
  - An accepted beat with `in_last_i[g]` set moves to `Process`.
- `Process`: `hash_process_o`=1 for one cycle, then go to `WaitDone`.
- `WaitDone`: on `hash_done_i`, register `digest_i` into `digest_o` and go to `Done`.
- `Done`:
  - `done_o[g]`=1.
  - `ptr` ← g+1, wrapping from NumReq-1 to 0.
  - Go to `Clear`.
- `Clear`:
  - `sha_en_o`=0 for one cycle, which scrubs the core's w, round and digest registers.
  - `grant_o`=0. Go to `Idle`.
- `sha_en_o`=1 in every state except `Idle` and `Clear`.
- `grant_o[g]`=1 from `Start` through `Done`.
- Abort: `req_i[g]` falling in any state from `Start` to `WaitDone` gives `abort_o[g]`=1 that cycle, then `Clear`. `ptr` advances and `digest_o` keeps its old value.
- Non-owners always see `in_ready_o`=0. Their requests stay pending; none is dropped.
- Beats after `in_last` are not accepted until the next grant to that requester.

## Timing
- Reset values: all outputs 0, state `Idle`, `ptr`=0, `digest_o`=0.
- Latency:
  - Request seen in `Idle` at cycle t gives `grant_o` and `hash_start_o` at t+1.
  - The first beat can be accepted at t+2.
  - The last beat accepted at cycle u gives `hash_process_o` at u+1.
  - `hash_done_i` at cycle v gives `done_o` and a valid `digest_o` at v+1. `digest_o` holds until the next `done_o`.
- Turnaround: `Done` to the next `Start` is 3 cycles (`Clear`, `Idle`, `Start`).
- Simultaneous requests: the owner is the lowest index at or above `ptr`.
- A new request arriving in the same cycle as `Done` waits for `Idle`.
- `hash_done_i` outside `WaitDone` is ignored.
- `in_last_i` is ignored when the latched length is 0.

## Configuration
- `SHA512_ARB_WDOG_EN` defined:
  - In `Stream`, a counter increments on each cycle with no accepted beat and clears on every accepted beat.
  - When it reaches `WdogCycles`, `abort_o[g]` pulses and the FSM goes to `Clear`.
- Not defined: no counter exists, and the FSM waits in `Stream` indefinitely.

## Test plan
- Requester 0 only, length 24 bits, word 0x6162630000000000, mask 0xE0, last=1 → `digest_o` word 0 = 0xddaf35a193617aba (SHA-512 of "abc"); `done_o[0]` 1 cycle after `hash_done_i`.
- `req_i`=0b11 in the same cycle from reset → requester 0 served first, then 1; second `hash_start_o` exactly 3 cycles after `done_o[0]`.
- Length 0, requester 1 → no `in_ready_o`; `hash_process_o` 1 cycle after `hash_start_o`; digest word 0 = 0xcf83e1357eefb8bd.
- `req_i[0]` dropped mid-`Stream` → `abort_o[0]` pulse, `sha_en_o`=0 next cycle, `digest_o` unchanged, pending requester 1 granted after `Clear`.
- With `SHA512_ARB_WDOG_EN` and `WdogCycles`=16, valid held low 16 cycles after the first beat → `abort_o` on the 16th stall cycle; without the macro, no abort after 10000 cycles.
- Async reset asserted in `WaitDone` → all outputs 0 immediately; a fresh "abc" job afterward gives the correct digest.
